// File: rtl/display_scan_driver.sv
// display_scan_driver: 8-digit multiplexed common-anode 7-segment driver with frame-synchronous shadow load
module display_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] LUT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };
  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic [5:0]    shadow [8];
  logic [5:0]    cur;
  logic          wrap, load, blank;
  always_comb begin
    cur   = shadow[idx];
    wrap  = div_cnt == CW'(REFRESH_DIV - 1);
    load  = wrap && idx == 3'd7;
    blank = div_cnt < CW'(BLANK_CYCLES) || !cur[5];
  end
  // scan counters, frame-boundary shadow capture and registered display outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt    <= '0;
      idx        <= '0;
      shadow     <= '{default: '0};
      an         <= 8'hFF;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= wrap ? '0 : div_cnt + 1'b1;
      idx        <= wrap ? idx + 3'd1 : idx;
      if (load) shadow <= '{d1, d2, d3, d4, d5, d6, d7, d8};
      frame_tick <= load;
      an         <= blank ? 8'hFF : ~(8'd1 << idx);
      seg        <= blank ? 8'hFF : {~LUT[cur[4:1]], ~cur[0]};
    end
  end
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: randomized check of the scan driver against a frame/time-based reference model
module tb_display_scan_driver;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FR = 8 * RD;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] d [8];
  logic [7:0] an, seg;
  logic       frame_tick;
  int         checks = 0;
  int         errors = 0;
  int         t = 0;
  logic [47:0] frames [$];
  string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  display_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clock(clock), .reset(reset),
    .d1(d[0]), .d2(d[1]), .d3(d[2]), .d4(d[3]),
    .d5(d[4]), .d6(d[5]), .d7(d[6]), .d8(d[7]),
    .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // segments lit for a hex value, a at bit 6 down to g at bit 0
  function automatic logic [6:0] lit(input logic [3:0] v);
    string s;
    logic [6:0] r;
    s = segs[v];
    r = '0;
    for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
    return r;
  endfunction

  function automatic logic [47:0] snap();
    return {d[7], d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    check("rst_tick", {7'd0, frame_tick}, 8'd0);
    reset = 1'b0;
    t = 0;
    frames = {48'd0};
  endtask

  // outputs at cycle t reflect the scan position of cycle t-1 and the inputs captured at the last frame end
  task automatic step();
    int s, f, p, slot, ph;
    logic [5:0] code;
    logic [7:0] ea, es;
    if (t % FR == FR - 1) frames.push_back(snap());
    @(posedge clock);
    #1;
    t++;
    s    = t - 1;
    f    = s / FR;
    p    = s % FR;
    slot = p / RD;
    ph   = p % RD;
    code = frames[f][slot*6 +: 6];
    ea   = (ph < BC || !code[5]) ? 8'hFF : ~(8'd1 << slot);
    es   = (ph < BC || !code[5]) ? 8'hFF : ~{lit(code[4:1]), code[0]};
    check("an", an, ea);
    check("seg", seg, es);
    check("tick", {7'd0, frame_tick}, {7'd0, t % FR == 0});
    check("one_anode", {7'd0, $countones(~an) <= 1}, 8'd1);
  endtask

  task automatic run_until(input int n, input bit rnd);
    while (t < n) begin
      if (rnd && $urandom_range(7) == 0) d[$urandom_range(7)] = 6'($urandom);
      step();
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) d[k] = 6'h00;
    d[0] = 6'h26;
    repeat (2) @(posedge clock);
    do_reset();
    while (t < 40) begin
      step();
      if (t == 20) check("tp_first_blank", an, 8'hFF);
      if (t == 32) check("tp_tick32", {7'd0, frame_tick}, 8'd1);
      if (t == 33) check("tp_an33", an, 8'hFF);
      if (t == 34) begin
        check("tp_an34", an, 8'hFE);
        check("tp_seg34", seg, 8'h0D);
      end
    end
    for (int k = 1; k < 8; k++) d[k] = 6'h31;
    d[0] = 6'h20;
    d[4] = 6'h14;
    while (t < 90) begin
      step();
      if (t == 60) check("tp_old_d1", seg, 8'hFF);
      if (t == 66) begin
        check("tp_an66", an, 8'hFE);
        check("tp_seg66", seg, 8'h03);
      end
      if (t == 70) begin
        check("tp_an70", an, 8'hFD);
        check("tp_seg70", seg, 8'h00);
      end
      if (t == 82) check("tp_disabled", an, 8'hFF);
    end
    for (int k = 0; k < 8; k++) d[k] = {1'b1, 4'(k), 1'b0};
    run_until(104, 1'b0);
    for (int k = 0; k < 8; k++) d[k] = {1'b1, 4'(k + 8), 1'b0};
    while (t < 170) begin
      step();
      if (t == 142) check("tp_seg_b", seg, 8'hC1);
      if (t == 158) check("tp_seg_F", seg, 8'h71);
    end
    run_until(300, 1'b1);
    do_reset();
    for (int k = 0; k < 8; k++) d[k] = {1'b1, 5'($urandom)};
    run_until(50, 1'b0);
    check("tp_an_low_pre_reset", {7'd0, an != 8'hFF}, 8'd1);
    do_reset();
    for (int k = 0; k < 8; k++) d[k] = {1'b1, 5'($urandom)};
    while (t < 40) begin
      step();
      if (t == 10) check("tp_post_reset_blank", an, 8'hFF);
      if (t == 32) check("tp_post_reset_tick", {7'd0, frame_tick}, 8'd1);
    end
    run_until(200, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Reader end of the clock's display interface: consumes the eight 6-bit digit codes d1..d8 and drives a time-multiplexed, 8-digit, common-anode 7-segment display.
- Contents: a refresh divider, a digit scanner, per-digit hex decode, anti-ghost blanking, and a frame-synchronous shadow copy of the inputs, so a frame never shows a mix of two input values.
- Sits between the clock/interface logic and the board display pins, in the 100 MHz domain.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz, 125 Hz frame). Legal: >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off. Legal: 1..REFRESH_DIV-1.

Ports:
- clock  in  1  system clock, 100 MHz
- reset  in  1  synchronous reset, active-high
- d1  in  6  digit code for the rightmost position (an[0])
- d2..d7  in  6 each  digit codes for an[1]..an[6]
- d8  in  6  digit code for the leftmost position (an[7])
- an  out  8  anode enables, active-low; an[k] selects digit k+1
- seg  out  8  cathodes, active-low; seg[7:0] = {a,b,c,d,e,f,g,dp}
- frame_tick  out  1  one-cycle pulse marking the first cycle of each new frame

Behaviour:
- Reset is synchronous and active-high; one clock; no other clock domains.
- Digit code format: bit5 = enable, bits4:1 = hex value 0..F, bit0 = decimal point (1 = lit).
- Reset (synchronous, active-high; dominates everything):
  - div_cnt = 0, idx = 0.
  - All shadow codes = 0 (all digits disabled).
  - an = 8'hFF, seg = 8'hFF, frame_tick = 0 on the cycle after reset is sampled.
- Asserting reset mid-frame aborts the scan. The first cycle with reset low is cycle 0 of a fresh frame with blank shadows.
- Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, idx increments modulo 8 (7 -> 0).
- Shadow load: all eight d inputs are captured in the cycle where div_cnt == REFRESH_DIV-1 and idx == 7.
  - Input changes at any other time are not displayed until the next load.
  - The first frame after reset shows nothing.
- frame_tick is registered: it is high for exactly the one cycle after a shadow load, which is the first cycle of the new frame (div_cnt == 0, idx == 0).
- Outputs are registered. an/seg at cycle t+1 are a function of div_cnt, idx and shadow[idx] at cycle t (one cycle latency):
  - If div_cnt < BLANK_CYCLES, or shadow[idx].enable == 0: an = 8'hFF, seg = 8'hFF.
  - Otherwise: an = ~(1 << idx), seg = {~decode(value), ~dp}.
- Exactly one anode is low, or none; never two.
- Decode (segments lit):
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg; 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg; C adef; d bcdeg; E adefg; F aefg
- dp is independent of value; a disabled digit suppresses its dp.
- No other handshake: inputs are level-sampled only at shadow load. Inputs need not be stable at any other time.

Test Plan:
(Sim parameters: REFRESH_DIV=4, BLANK_CYCLES=1; frame = 32 cycles; cycle 0 = first edge with reset low.)
- Reset release, d1 = 6'h26 (enabled, 3, no dp) held -> an = 8'hFF for cycles 1..32. frame_tick = 1 only at cycle 32. Cycle 33 an = 8'hFF (blank slot start). Cycles 34..36 an = 8'hFE, seg = 8'h0D.
- All d = 6'h31 (enabled, 8, dp) -> in frame 2, each slot k shows an = ~(1<<k), seg = 8'h00 for 3 cycles after 1 blank cycle. No cycle has two anodes low.
- d5 = 6'h14 (disabled, A) -> slot 4 keeps an = 8'hFF, seg = 8'hFF for all 4 cycles every frame; other slots are unaffected.
- Change d1 from 6'h26 to 6'h20 (enabled, 0) at cycle 40 -> slot 0 continues seg = 8'h0D through frame 2. Frame 3 (from cycle 64) shows seg = 8'h03.
- Sweep value 0..F with enable, dp = 0 -> seg matches the decode table for every value, e.g. F -> 8'h71, b -> 8'hC1.
- Assert reset for 1 cycle at cycle 50 (mid-slot, an low) -> an = 8'hFF, seg = 8'hFF the next cycle. The next frame_tick occurs 32 cycles after reset is released, and that frame is blank.
